// File: rtl/aim_controller_if.sv
// rtl/aim_controller_if.sv - button/result inputs and aim outputs between player front end and trajectory_calc
//
// Signals
//   btn_left/right/up/down/sel/dir/fire  synchronized button levels
//   result_valid                         one-cycle done pulse from trajectory_calc
//   x_pos, rise, run, direction          aim values presented to trajectory_calc
//   shoot                                one-cycle shot request
//   sel_run, busy, timeout               status for display / supervision
// Modports
//   master  the aim controller (consumes buttons, drives aim/status)
//   slave   the surrounding system (drives buttons, consumes aim/status)

interface aim_controller_if;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic       btn_sel;
    logic       btn_dir;
    logic       btn_fire;
    logic       result_valid;
    logic [4:0] x_pos;
    logic [4:0] rise;
    logic [4:0] run;
    logic       direction;
    logic       shoot;
    logic       sel_run;
    logic       busy;
    logic       timeout;

    modport master (
        input  btn_left, btn_right, btn_up, btn_down, btn_sel, btn_dir, btn_fire,
        input  result_valid,
        output x_pos, rise, run, direction, shoot, sel_run, busy, timeout
    );

    modport slave (
        output btn_left, btn_right, btn_up, btn_down, btn_sel, btn_dir, btn_fire,
        output result_valid,
        input  x_pos, rise, run, direction, shoot, sel_run, busy, timeout
    );
endinterface

// File: rtl/aim_controller.sv
// rtl/aim_controller.sv - button-driven aim state and shot sequencing in front of trajectory_calc
//
// Ports
//   clk   in  system clock, all state on rising edge
//   rst   in  synchronous active-high reset
//   aim   aim_controller_if.master: buttons and result_valid in; x_pos, rise, run,
//         direction, shoot, sel_run, busy, timeout out (all outputs registered)

module aim_controller #(
    parameter int X_INIT    = 16,
    parameter int RISE_INIT = 1,
    parameter int RUN_INIT  = 1,
    parameter int TIMEOUT   = 40
) (
    input  logic              clk,
    input  logic              rst,
    aim_controller_if.master  aim
);

    typedef enum logic [1:0] {
        ST_AIM  = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [4:0] X_RST    = 5'(X_INIT);
    localparam logic [4:0] RISE_RST = 5'(RISE_INIT);
    localparam logic [4:0] RUN_RST  = 5'(RUN_INIT);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    // Button bit positions in the packed vectors below.
    localparam int B_LEFT  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_UP    = 2;
    localparam int B_DOWN  = 3;
    localparam int B_SEL   = 4;
    localparam int B_DIR   = 5;
    localparam int B_FIRE  = 6;

    state_t     state;
    logic [6:0] btn;
    logic [6:0] btn_prev;
    logic [6:0] press;
    logic [7:0] wait_cnt;

    logic [4:0] x_q;
    logic [4:0] rise_q;
    logic [4:0] run_q;
    logic       dir_q;
    logic       sel_q;
    logic       shoot_q;
    logic       busy_q;
    logic       timeout_q;

    logic [4:0] x_next;
    logic [4:0] rise_next;
    logic [4:0] run_next;
    logic       slope_up;
    logic       slope_dn;

    assign btn = {aim.btn_fire, aim.btn_dir, aim.btn_sel, aim.btn_down,
                  aim.btn_up, aim.btn_right, aim.btn_left};

    // Rising-edge detect; prev regs reset to 1 so a button held through reset is not a press.
    assign press = btn & ~btn_prev;

    // Opposing presses in the same cycle cancel.
    assign slope_up = press[B_UP] & ~press[B_DOWN];
    assign slope_dn = press[B_DOWN] & ~press[B_UP];

    always_comb begin
        x_next    = x_q;
        rise_next = rise_q;
        run_next  = run_q;

        if (press[B_RIGHT] && !press[B_LEFT] && x_q != 5'd31)
            x_next = x_q + 5'd1;
        else if (press[B_LEFT] && !press[B_RIGHT] && x_q != 5'd0)
            x_next = x_q - 5'd1;

        // sel_q here is the value before any same-cycle sel press takes effect.
        if (!sel_q) begin
            // rise must never reach 0 or trajectory_calc never terminates.
            if (slope_up && rise_q != 5'd31)
                rise_next = rise_q + 5'd1;
            else if (slope_dn && rise_q > 5'd1)
                rise_next = rise_q - 5'd1;
        end else begin
            if (slope_up && run_q != 5'd31)
                run_next = run_q + 5'd1;
            else if (slope_dn && run_q != 5'd0)
                run_next = run_q - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_AIM;
            btn_prev  <= '1;
            wait_cnt  <= 8'd0;
            x_q       <= X_RST;
            rise_q    <= RISE_RST;
            run_q     <= RUN_RST;
            dir_q     <= 1'b0;
            sel_q     <= 1'b0;
            shoot_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            btn_prev  <= btn;
            shoot_q   <= 1'b0;
            timeout_q <= 1'b0;

            case (state)
                ST_AIM: begin
                    busy_q <= 1'b0;
                    if (press[B_FIRE]) begin
                        // Fire wins; edits pressed in the same cycle are discarded.
                        state   <= ST_FIRE;
                        shoot_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        x_q    <= x_next;
                        rise_q <= rise_next;
                        run_q  <= run_next;
                        sel_q  <= sel_q ^ press[B_SEL];
                        dir_q  <= dir_q ^ press[B_DIR];
                    end
                end

                ST_FIRE: begin
                    state    <= ST_WAIT;
                    busy_q   <= 1'b1;
                    wait_cnt <= 8'd0;
                end

                ST_WAIT: begin
                    if (aim.result_valid) begin
                        state  <= ST_AIM;
                        busy_q <= 1'b0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= ST_AIM;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        busy_q   <= 1'b1;
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                default: begin
                    state  <= ST_AIM;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign aim.x_pos     = x_q;
    assign aim.rise      = rise_q;
    assign aim.run       = run_q;
    assign aim.direction = dir_q;
    assign aim.sel_run   = sel_q;
    assign aim.shoot     = shoot_q;
    assign aim.busy      = busy_q;
    assign aim.timeout   = timeout_q;

endmodule

// File: tb/tb_aim_controller.sv
// tb/tb_aim_controller.sv - self-checking bench for aim_controller

module tb_aim_controller;

    // Button mask bits: {fire, dir, sel, down, up, right, left}
    localparam logic [6:0] L  = 7'b0000001;
    localparam logic [6:0] R  = 7'b0000010;
    localparam logic [6:0] U  = 7'b0000100;
    localparam logic [6:0] D  = 7'b0001000;
    localparam logic [6:0] S  = 7'b0010000;
    localparam logic [6:0] DR = 7'b0100000;
    localparam logic [6:0] F  = 7'b1000000;
    localparam logic [6:0] NB = 7'b0000000;

    typedef struct {
        logic [4:0] x;
        logic [4:0] rise;
        logic [4:0] run;
        logic       dir;
        logic       sel;
        logic       shoot;
        logic       busy;
        logic       tmo;
    } exp_t;

    typedef struct {
        logic [6:0] btn;
        logic       rv;
        logic [4:0] x;
        logic [4:0] rise;
        logic [4:0] run;
        logic       dir;
        logic       sel;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    exp_t exp_q[$];
    exp_t cur;
    vec_t vecs[29];

    aim_controller_if bus ();

    aim_controller #(
        .X_INIT    (16),
        .RISE_INIT (1),
        .RUN_INIT  (1),
        .TIMEOUT   (40)
    ) dut (
        .clk (clk),
        .rst (rst),
        .aim (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d actual=running expected=finished", cycle);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cycle, act, expv);
        end
    endtask

    function automatic exp_t mk(input int x, input int rise, input int run, input int dir,
                                input int sel, input int shoot, input int busy, input int tmo);
        exp_t e;
        e.x = 5'(x); e.rise = 5'(rise); e.run = 5'(run);
        e.dir = 1'(dir); e.sel = 1'(sel);
        e.shoot = 1'(shoot); e.busy = 1'(busy); e.tmo = 1'(tmo);
        return e;
    endfunction

    // Drive one cycle, queue the expectation, compare after the edge.
    task automatic cyc(input logic [6:0] b, input logic rv, input logic r, input exp_t e);
        exp_t got;
        rst = r;
        bus.btn_left  = b[0];
        bus.btn_right = b[1];
        bus.btn_up    = b[2];
        bus.btn_down  = b[3];
        bus.btn_sel   = b[4];
        bus.btn_dir   = b[5];
        bus.btn_fire  = b[6];
        bus.result_valid = rv;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cycle++;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty cycle=%0d actual=0 expected=1", cycle);
        end else begin
            got = exp_q.pop_front();
            chk("x_pos",     int'(bus.x_pos),     int'(got.x));
            chk("rise",      int'(bus.rise),      int'(got.rise));
            chk("run",       int'(bus.run),       int'(got.run));
            chk("direction", int'(bus.direction), int'(got.dir));
            chk("sel_run",   int'(bus.sel_run),   int'(got.sel));
            chk("shoot",     int'(bus.shoot),     int'(got.shoot));
            chk("busy",      int'(bus.busy),      int'(got.busy));
            chk("timeout",   int'(bus.timeout),   int'(got.tmo));
        end
    endtask

    // Aim-state helper: press for one cycle then release for one cycle, same expectation.
    task automatic press_aim(input logic [6:0] b, input logic rv, input exp_t e);
        cyc(b, rv, 1'b0, e);
        cyc(NB, 1'b0, 1'b0, e);
    endtask

    initial begin
        // Table starts from x=0 rise=1 run=1 dir=0 sel=0.
        vecs[0]  = '{D,       1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b0};
        vecs[1]  = '{D,       1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b0};
        vecs[2]  = '{D,       1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b0};
        vecs[3]  = '{S,       1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b1};
        vecs[4]  = '{U,       1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1};
        vecs[5]  = '{U,       1'b0, 5'd0, 5'd1, 5'd3, 1'b0, 1'b1};
        vecs[6]  = '{U,       1'b0, 5'd0, 5'd1, 5'd4, 1'b0, 1'b1};
        vecs[7]  = '{U,       1'b0, 5'd0, 5'd1, 5'd5, 1'b0, 1'b1};
        vecs[8]  = '{S,       1'b0, 5'd0, 5'd1, 5'd5, 1'b0, 1'b0};
        vecs[9]  = '{S|U,     1'b0, 5'd0, 5'd2, 5'd5, 1'b0, 1'b1};
        vecs[10] = '{U|D,     1'b0, 5'd0, 5'd2, 5'd5, 1'b0, 1'b1};
        vecs[11] = '{D,       1'b0, 5'd0, 5'd2, 5'd4, 1'b0, 1'b1};
        vecs[12] = '{D,       1'b0, 5'd0, 5'd2, 5'd3, 1'b0, 1'b1};
        vecs[13] = '{D,       1'b0, 5'd0, 5'd2, 5'd2, 1'b0, 1'b1};
        vecs[14] = '{D,       1'b0, 5'd0, 5'd2, 5'd1, 1'b0, 1'b1};
        vecs[15] = '{D,       1'b0, 5'd0, 5'd2, 5'd0, 1'b0, 1'b1};
        vecs[16] = '{D,       1'b0, 5'd0, 5'd2, 5'd0, 1'b0, 1'b1};
        vecs[17] = '{R,       1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1};
        vecs[18] = '{L|R,     1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1};
        vecs[19] = '{DR,      1'b0, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1};
        vecs[20] = '{DR|L,    1'b0, 5'd0, 5'd2, 5'd0, 1'b0, 1'b1};
        vecs[21] = '{L,       1'b0, 5'd0, 5'd2, 5'd0, 1'b0, 1'b1};
        vecs[22] = '{S|D,     1'b0, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0};
        vecs[23] = '{D,       1'b0, 5'd0, 5'd1, 5'd0, 1'b0, 1'b0};
        vecs[24] = '{D,       1'b0, 5'd0, 5'd1, 5'd0, 1'b0, 1'b0};
        vecs[25] = '{U,       1'b0, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0};
        vecs[26] = '{NB,      1'b1, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0};
        vecs[27] = '{U,       1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0};
        vecs[28] = '{R|U|DR,  1'b0, 5'd1, 5'd4, 5'd0, 1'b1, 1'b0};

        // Reset with fire held: no shot, defaults everywhere.
        cyc(F, 1'b0, 1'b1, mk(16, 1, 1, 0, 0, 0, 0, 0));
        cyc(F, 1'b0, 1'b1, mk(16, 1, 1, 0, 0, 0, 0, 0));
        cyc(F, 1'b0, 1'b0, mk(16, 1, 1, 0, 0, 0, 0, 0));
        cyc(F, 1'b0, 1'b0, mk(16, 1, 1, 0, 0, 0, 0, 0));
        cyc(NB, 1'b0, 1'b0, mk(16, 1, 1, 0, 0, 0, 0, 0));

        // x saturation: 20 rights from 16, then 40 lefts.
        for (int i = 1; i <= 20; i++)
            press_aim(R, 1'b0, mk((16 + i > 31) ? 31 : 16 + i, 1, 1, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 40; i++)
            press_aim(L, 1'b0, mk((31 - i < 0) ? 0 : 31 - i, 1, 1, 0, 0, 0, 0, 0));

        // Edit table.
        for (int i = 0; i < 29; i++)
            press_aim(vecs[i].btn, vecs[i].rv,
                      mk(vecs[i].x, vecs[i].rise, vecs[i].run, vecs[i].dir, vecs[i].sel, 0, 0, 0));

        // Shot with fire+right: fire wins, one-cycle shoot, WAIT ignores presses,
        // result_valid 12 cycles into WAIT returns to AIM.
        cur = mk(1, 4, 0, 1, 0, 0, 1, 0);
        cyc(F|R, 1'b0, 1'b0, mk(1, 4, 0, 1, 0, 1, 1, 0));
        cyc(NB, 1'b0, 1'b0, cur);
        for (int i = 2; i <= 12; i++)
            cyc((i % 2 == 0) ? (L|U|S|DR) : NB, 1'b0, 1'b0, cur);
        cyc(NB, 1'b1, 1'b0, mk(1, 4, 0, 1, 0, 0, 0, 0));

        // Held button: one action only.
        cyc(R, 1'b0, 1'b0, mk(2, 4, 0, 1, 0, 0, 0, 0));
        cyc(R, 1'b0, 1'b0, mk(2, 4, 0, 1, 0, 0, 0, 0));
        cyc(R, 1'b0, 1'b0, mk(2, 4, 0, 1, 0, 0, 0, 0));
        cyc(NB, 1'b0, 1'b0, mk(2, 4, 0, 1, 0, 0, 0, 0));

        // No result: timeout pulse 41 edges after the fire edge, for one cycle.
        cyc(F, 1'b0, 1'b0, mk(2, 4, 0, 1, 0, 1, 1, 0));
        for (int n = 1; n <= 40; n++)
            cyc(NB, 1'b0, 1'b0, mk(2, 4, 0, 1, 0, 0, 1, 0));
        cyc(NB, 1'b0, 1'b0, mk(2, 4, 0, 1, 0, 0, 0, 1));
        cyc(NB, 1'b0, 1'b0, mk(2, 4, 0, 1, 0, 0, 0, 0));

        // result_valid on the timeout cycle: no timeout pulse.
        cyc(F, 1'b0, 1'b0, mk(2, 4, 0, 1, 0, 1, 1, 0));
        for (int n = 1; n <= 40; n++)
            cyc(NB, 1'b0, 1'b0, mk(2, 4, 0, 1, 0, 0, 1, 0));
        cyc(NB, 1'b1, 1'b0, mk(2, 4, 0, 1, 0, 0, 0, 0));
        cyc(NB, 1'b0, 1'b0, mk(2, 4, 0, 1, 0, 0, 0, 0));

        // Reset mid-WAIT restores defaults and drops busy.
        cyc(F, 1'b0, 1'b0, mk(2, 4, 0, 1, 0, 1, 1, 0));
        for (int n = 1; n <= 5; n++)
            cyc(NB, 1'b0, 1'b0, mk(2, 4, 0, 1, 0, 0, 1, 0));
        cyc(NB, 1'b0, 1'b1, mk(16, 1, 1, 0, 0, 0, 0, 0));
        cyc(NB, 1'b0, 1'b0, mk(16, 1, 1, 0, 0, 0, 0, 0));
        cyc(R, 1'b0, 1'b0, mk(17, 1, 1, 0, 0, 0, 0, 0));
        cyc(NB, 1'b0, 1'b0, mk(17, 1, 1, 0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
